// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory interface among NUM_PORTS requesters
// using fixed-priority or round-robin grant, with per-port read squash and ready/stall handshakes.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_PORTS-1:0]        i_req_re,
    input  logic [NUM_PORTS-1:0]        i_req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] i_req_wdata,
    input  logic [NUM_PORTS-1:0]        i_squash,
    output logic [DATA_W-1:0]           o_port_rdata,
    output logic [NUM_PORTS-1:0]        o_port_ready,
    output logic [NUM_PORTS-1:0]        o_port_stall,
    output logic [ADDR_W-1:0]           o_addr,
    output logic [DATA_W-1:0]           o_data_in,
    output logic                        o_omem_re,
    output logic                        o_omem_wr,
    input  logic [DATA_W-1:0]           i_data_out,
    input  logic                        i_mem_ready
);
    localparam int G_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [G_W-1:0] W_TOP = G_W'(NUM_PORTS - 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                r_state;
    logic [G_W-1:0]        r_g;
    logic [G_W-1:0]        r_last;
    logic                  r_kill;
    logic                  r_re;
    logic                  r_wr;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic [NUM_PORTS-1:0]  r_ready;
    logic [NUM_PORTS-1:0]  w_req;
    logic [G_W-1:0]        w_sel;
    logic [G_W-1:0]        w_idx;
    logic                  w_found;
    assign w_req        = i_req_re | i_req_wr;
    assign o_port_stall = w_req & ~r_ready;
    assign o_port_ready = r_ready;
    assign o_port_rdata = r_rdata;
    assign o_addr       = r_addr;
    assign o_data_in    = r_wdata;
    assign o_omem_re    = r_re;
    assign o_omem_wr    = r_wr;
    // Fixed priority is a scan that always starts just after the top port, so port 0 is seen first.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = (RR_MODE != 0) ? r_last : W_TOP;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = (w_idx == W_TOP) ? '0 : w_idx + 1'b1;
            if (!w_found && w_req[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_last  <= W_TOP;
            r_kill  <= 1'b0;
            r_re    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= ACCESS;
                        r_g     <= w_sel;
                        r_last  <= w_sel;
                        r_kill  <= 1'b0;
                        r_addr  <= i_req_addr[w_sel*ADDR_W +: ADDR_W];
                        r_wdata <= i_req_wdata[w_sel*DATA_W +: DATA_W];
                        r_wr    <= i_req_wr[w_sel];
                        r_re    <= ~i_req_wr[w_sel];
                    end
                end
                ACCESS: begin
                    if (i_squash[r_g])
                        r_kill <= 1'b1;
                    // A squashed read still runs to completion on the bus; only the ready pulse is withheld.
                    if (i_mem_ready) begin
                        r_state <= RESP;
                        r_rdata <= i_data_out;
                        r_re    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_ready <= (r_kill | i_squash[r_g]) ? '0 : (NUM_PORTS'(1) << r_g);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= '0;
                end
            endcase
        end
    end
endmodule
